// File: rtl/tty_in.sv
// Host-to-CPU character input port: byte FIFO fed by a valid/ready host
// interface, drained through a two-register tri-state CPU bus window.
module tty_in #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr,
  input  logic [31:0] data,
  output logic [31:0] out,
  input  logic        rd,
  input  logic        wr,
  input  logic        en,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;

  logic          empty, full;
  logic          pop, push, sts_wr;
  logic [7:0]    head_byte;
  logic [7:0]    cnt_field;
  logic [31:0]   rd_data;
  logic          unused_data;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign char_ready = !full;
  assign head_byte  = mem_q[rd_ptr_q];
  assign cnt_field  = 8'(count_q);

  // pop needs a byte present; push needs room, so empty/full cases resolve naturally
  assign pop    = en && rd && !addr && !empty;
  assign push   = char_valid && !full;
  assign sts_wr = en && wr && addr;

  assign unused_data = ^{data[31:4], data[2], data[0]};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    irq_d    = irq_en_q && !empty;

    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (sts_wr) begin
      irq_en_d = data[1];
      if (data[3]) ovf_d = 1'b0;
    end
    // a rejected byte in the same cycle as a clear still records the overflow
    if (char_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && rst) mem_q[wr_ptr_q] <= char_in;
  end

  always_comb begin
    rd_data = '0;
    if (!addr) begin
      if (!empty) rd_data = {23'b0, 1'b1, head_byte};
    end else begin
      rd_data = {16'b0, cnt_field, 4'b0, ovf_q, irq_en_q, full, empty};
    end
  end

  assign out = (en && rd && rst) ? rd_data : 'z;
  assign irq = irq_q;

endmodule

// File: tb/tb_tty_in.sv
// Bench for tty_in: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the port's register/FIFO behaviour.
module tb_tty_in;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] OTH   = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        addr = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        en = 1'b0;
  logic        char_valid = 1'b0;
  logic        oth_en = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  char_in = '0;
  wire  [31:0] bus;
  logic        char_ready;
  logic        irq;

  // another responder on the shared bus; it reads back only if the DUT lets go
  assign bus = oth_en ? OTH : 32'bz;

  tty_in #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .data       (data),
    .out        (bus),
    .rd         (rd),
    .wr         (wr),
    .en         (en),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  logic [7:0] mq[$];
  logic       m_irq_en = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_irq = 1'b0;
  logic       obs_ready;
  logic       obs_irq;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic a);
    logic [31:0] r;
    r = '0;
    if (!a) begin
      if (mq.size() != 0) r = {23'b0, 1'b1, mq[0]};
    end else begin
      r[0]    = (mq.size() == 0);
      r[1]    = (mq.size() == DEPTH);
      r[2]    = m_irq_en;
      r[3]    = m_ovf;
      r[15:8] = 8'(mq.size());
    end
    return r;
  endfunction

  task automatic m_step(input logic a, input logic [31:0] d, input logic r, input logic w,
                        input logic e, input logic [7:0] ch, input logic cv);
    logic was_full, do_pop, do_push;
    was_full = (mq.size() == DEPTH);
    do_pop   = e && r && !a && (mq.size() != 0);
    do_push  = cv && !was_full;
    m_irq    = m_irq_en && (mq.size() != 0);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(ch);
    if (e && w && a) begin
      m_irq_en = d[1];
      if (d[3]) m_ovf = 1'b0;
    end
    if (cv && was_full) m_ovf = 1'b1;
  endtask

  task automatic cyc(input logic a, input logic [31:0] d, input logic r, input logic w,
                     input logic e, input logic [7:0] ch, input logic cv, output logic [31:0] rdv);
    @(negedge clk);
    addr = a; data = d; rd = r; wr = w; en = e; char_in = ch; char_valid = cv;
    oth_en = !(e && r);
    #1;
    chk("out", bus, (e && r) ? m_read(a) : OTH);
    chk("ready", {31'b0, char_ready}, {31'b0, mq.size() != DEPTH});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    rdv = bus; obs_ready = char_ready; obs_irq = irq;
    @(posedge clk);
    m_step(a, d, r, w, e, ch, cv);
    #1;
    rd = 1'b0; wr = 1'b0; en = 1'b0; char_valid = 1'b0; oth_en = 1'b1;
  endtask

  task automatic push(input logic [7:0] ch);
    logic [31:0] v;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, ch, 1'b1, v);
  endtask

  task automatic rd_data(output logic [31:0] v);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, v);
  endtask

  task automatic rd_sts(output logic [31:0] v);
    cyc(1'b1, '0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, v);
  endtask

  task automatic wr_sts(input logic [31:0] d);
    logic [31:0] v;
    cyc(1'b1, d, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, v);
  endtask

  task automatic idle();
    logic [31:0] v;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; rd = 1'b1; addr = 1'b1; char_valid = 1'b1; char_in = 8'hEE;
    oth_en = 1'b1;
    #1;
    chk("rst_out", bus, OTH);
    chk("rst_ready", {31'b0, char_ready}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    mq.delete(); m_irq_en = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b0; rd = 1'b0; addr = 1'b0; char_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  exp_b;
    int unsigned pp, rp;

    do_reset();
    rd_sts(v);           chk("reset_sts", v, 32'h1);

    push(8'h48); push(8'h69);
    rd_data(v);          chk("hi_0", v, 32'h148);
    rd_data(v);          chk("hi_1", v, 32'h169);
    rd_data(v);          chk("hi_empty", v, 32'h0);
    rd_sts(v);           chk("hi_sts", v, 32'h1);

    for (int i = 0; i < 8; i++) push(8'(i));
    rd_sts(v);           chk("full_sts", v, 32'h0802);
    chk("full_ready", {31'b0, obs_ready}, 32'h0);
    cyc(1'b1, '0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, v);
    rd_sts(v);           chk("ovf_sts", v, 32'h080A);
    rd_data(v);          chk("full_pop", v, 32'h100);
    rd_sts(v);           chk("after_pop_sts", v, 32'h0708);
    chk("after_pop_ready", {31'b0, obs_ready}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      rd_data(v);        chk("drain", v, 32'h100 | 32'(i));
    end

    wr_sts(32'h2);
    push(8'h77);
    idle();              chk("irq_lat0", {31'b0, obs_irq}, 32'h0);
    idle();              chk("irq_set", {31'b0, obs_irq}, 32'h1);
    rd_data(v);          chk("irq_pop", v, 32'h177);
    idle();              chk("irq_hold", {31'b0, obs_irq}, 32'h1);
    idle();              chk("irq_clr", {31'b0, obs_irq}, 32'h0);
    rd_sts(v);           chk("ovf_kept", v, 32'h000D);
    wr_sts(32'h8);
    rd_sts(v);           chk("ovf_clr", v, 32'h1);

    push(8'h11); push(8'h22); push(8'h33);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, v);
    chk("pp_head", v, 32'h111);
    rd_sts(v);           chk("pp_count", v, 32'h0300);
    rd_data(v);          chk("pp_0", v, 32'h122);
    rd_data(v);          chk("pp_1", v, 32'h133);
    rd_data(v);          chk("pp_2", v, 32'h1AA);

    wr_sts(32'h2);
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    idle();              chk("pre_rst_irq", {31'b0, obs_irq}, 32'h1);
    do_reset();
    rd_sts(v);           chk("post_rst_sts", v, 32'h1);
    push(8'h5C);
    rd_data(v);          chk("post_rst_data", v, 32'h15C);

    push(8'h31);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, v);
    chk("no_en_out", v, OTH);
    rd_sts(v);           chk("no_en_count", v, 32'h0100);
    exp_b = 8'h31;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b1, v);
      chk("wrap", v, {23'b0, 1'b1, exp_b});
      exp_b = 8'(8'h40 + i);
    end
    rd_data(v);          chk("wrap_last", v, {23'b0, 1'b1, exp_b});

    pp = 50; rp = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        pp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) == 0), $urandom,
            1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 99) < 85), 8'($urandom),
            1'($urandom_range(0, 99) < pp), v);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
